eth_rx_frame_writer: RTL and testbench

- Receive-side stage directly upstream of the 16-bit port A of the ethernet frame buffer (8K x 16 port A / 2K x 64 port B dual-port RAM).
- Takes the MAC's byte stream and writes each byte into a circular buffer through byte-enabled 16-bit writes.
- Checks frame length and error status and rolls back rejected frames.
- Hands each accepted frame to the host side as a descriptor (base word address and byte length). The host frees space by advancing rd_ptr.

---
 rtl/eth_rx_pkg.sv | 22 ++
 rtl/eth_rx_frame_writer.sv | 171 +++++++++++++++++
 tb/tb_eth_rx_frame_writer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the receive frame writer.
// desc_t is sized for the default 13-bit word address and 11-bit length.
package eth_rx_pkg;

  localparam int ADDR_W_DEF      = 13;
  localparam int LEN_W_DEF       = 11;
  localparam int MAX_FRAME_BYTES = 1536;
  localparam int MIN_FRAME_BYTES = 14;
  localparam int MAX_FRAME_WORDS = (MAX_FRAME_BYTES + 1) / 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] base;
    logic [LEN_W_DEF-1:0]  len;
  } desc_t;

endpackage

// File: rtl/eth_rx_frame_writer.sv
// Packs the MAC byte stream into a 16-bit circular frame buffer, rolls back
// rejected frames and publishes accepted frames as {base, len} descriptors.
module eth_rx_frame_writer #(
  parameter int ADDR_W          = eth_rx_pkg::ADDR_W_DEF,
  parameter int MAX_FRAME_BYTES = eth_rx_pkg::MAX_FRAME_BYTES,
  parameter int MIN_FRAME_BYTES = eth_rx_pkg::MIN_FRAME_BYTES,
  parameter int LEN_W           = eth_rx_pkg::LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic              rx_last,
  input  logic              rx_err,
  output logic              ram_en,
  output logic [1:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_din,
  input  logic [ADDR_W-1:0] rd_ptr,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [ADDR_W-1:0] desc_base,
  output logic [LEN_W-1:0]  desc_len,
  output logic [15:0]       drop_cnt
);

  import eth_rx_pkg::state_e;
  import eth_rx_pkg::desc_t;
  import eth_rx_pkg::ST_IDLE;
  import eth_rx_pkg::ST_RECV;
  import eth_rx_pkg::ST_DROP;

  localparam int MAX_WORDS = (MAX_FRAME_BYTES + 1) / 2;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               ram_en_q, ram_en_d;
  logic [1:0]         ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic [15:0]        ram_din_q, ram_din_d;
  logic               desc_valid_q, desc_valid_d;
  desc_t              desc_q, desc_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;

  logic [ADDR_W-1:0]  free_words;
  logic               admit;
  logic               done;
  logic               reject;
  logic [ADDR_W-1:0]  fin_base;
  logic [LEN_W-1:0]   fin_len;
  logic               fin_ok;

  // One word is always left unused so wr_ptr==rd_ptr unambiguously means empty.
  assign free_words = rd_ptr - wr_ptr_q - ADDR_W'(1);
  assign admit      = (free_words >= ADDR_W'(MAX_WORDS)) && (!desc_valid_q || desc_ready);
  assign fin_ok     = !rx_err && (fin_len >= LEN_W'(MIN_FRAME_BYTES));

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    ram_en_d     = 1'b0;
    ram_we_d     = 2'b00;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    desc_valid_d = desc_valid_q && !desc_ready;
    desc_d       = desc_q;
    drop_cnt_d   = drop_cnt_q;
    done         = 1'b0;
    reject       = 1'b0;
    fin_base     = base_q;
    fin_len      = cnt_q + LEN_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if (admit) begin
            base_d     = wr_ptr_q;
            cnt_d      = LEN_W'(1);
            ram_en_d   = 1'b1;
            ram_we_d   = 2'b01;
            ram_addr_d = wr_ptr_q;
            ram_din_d  = {rx_byte, rx_byte};
            fin_base   = wr_ptr_q;
            fin_len    = LEN_W'(1);
            if (rx_last) done = 1'b1;
            else         state_d = ST_RECV;
          end else begin
            reject = 1'b1;
            if (!rx_last) state_d = ST_DROP;
          end
        end
      end
      ST_RECV: begin
        if (rx_valid) begin
          if (cnt_q >= LEN_W'(MAX_FRAME_BYTES)) begin
            // Oversize: stop writing; the already-written words are simply abandoned.
            reject  = 1'b1;
            state_d = rx_last ? ST_IDLE : ST_DROP;
          end else begin
            ram_en_d   = 1'b1;
            ram_we_d   = cnt_q[0] ? 2'b10 : 2'b01;
            ram_addr_d = base_q + ADDR_W'(cnt_q >> 1);
            ram_din_d  = {rx_byte, rx_byte};
            cnt_d      = cnt_q + LEN_W'(1);
            if (rx_last) done = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (rx_valid && rx_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (done) begin
      state_d = ST_IDLE;
      if (fin_ok) begin
        desc_valid_d = 1'b1;
        desc_d.base  = fin_base;
        desc_d.len   = fin_len;
        wr_ptr_d     = fin_base + ADDR_W'((fin_len + LEN_W'(1)) >> 1);
      end else begin
        reject = 1'b1;
      end
    end

    if (reject && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      base_q       <= '0;
      cnt_q        <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 2'b00;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      desc_valid_q <= 1'b0;
      desc_q       <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      desc_valid_q <= desc_valid_d;
      desc_q       <= desc_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign desc_valid = desc_valid_q;
  assign desc_base  = desc_q.base;
  assign desc_len   = desc_q.len;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_frame_writer.sv
// Bench for eth_rx_frame_writer: table of frames with expected base,
// descriptor and drop count; RAM writes checked through an expected queue.
module tb_eth_rx_frame_writer;

  localparam int AW = 13;
  localparam int LW = 11;
  localparam int WW = AW + 2 + 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = '0;
  logic          rx_last = 1'b0;
  logic          rx_err = 1'b0;
  logic          ram_en;
  logic [1:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_din;
  logic [AW-1:0] rd_ptr = '0;
  logic          desc_valid;
  logic          desc_ready = 1'b0;
  logic [AW-1:0] desc_base;
  logic [LW-1:0] desc_len;
  logic [15:0]   drop_cnt;

  always #5 clk = ~clk;

  eth_rx_frame_writer dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .rx_last    (rx_last),
    .rx_err     (rx_err),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .rd_ptr     (rd_ptr),
    .desc_valid (desc_valid),
    .desc_ready (desc_ready),
    .desc_base  (desc_base),
    .desc_len   (desc_len),
    .drop_cnt   (drop_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [WW-1:0] exp_q[$];

  typedef struct {
    int n;
    bit err;
    int rdp;
    bit consume;
    int base;
    bit admit;
    bit dv;
    int db;
    int dl;
    int drops;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(int n, bit err, int rdp, bit consume, int base, bit admit,
                              bit dv, int db, int dl, int drops);
    vec_t v;
    v.n = n; v.err = err; v.rdp = rdp; v.consume = consume; v.base = base;
    v.admit = admit; v.dv = dv; v.db = db; v.dl = dl; v.drops = drops;
    vecs.push_back(v);
  endfunction

  // Write monitor: every port-A write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rstn && ram_en) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d we=%b din=0x%h, expected no write",
                 ram_addr, ram_we, ram_din);
      end else begin
        check("ram_write", 64'({ram_addr, ram_we, ram_din}), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_frame(input int n, input bit err, input logic [AW-1:0] base,
                            input int nwr, input logic [7:0] seed, input bit ready_first);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      if (k > 0 && $urandom_range(0, 3) == 0) begin
        rx_valid = 1'b0;
        rx_last  = 1'($urandom_range(0, 1));
        rx_err   = 1'($urandom_range(0, 1));
        rx_byte  = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
      end
      b          = 8'(k) + seed;
      rx_valid   = 1'b1;
      rx_byte    = b;
      rx_last    = (k == n - 1);
      rx_err     = (k == n - 1) ? err : 1'($urandom_range(0, 1));
      desc_ready = ready_first && (k == 0);
      if (k < nwr)
        exp_q.push_back({base + AW'(k >> 1), (k % 2 == 1) ? 2'b10 : 2'b01, b, b});
      @(posedge clk); #1;
    end
    rx_valid   = 1'b0;
    rx_last    = 1'b0;
    rx_err     = 1'b0;
    desc_ready = 1'b0;
  endtask

  task automatic check_frame(input string name, input bit dv, input int db, input int dl,
                             input int drops);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    check({name, "_desc_valid"}, 64'(desc_valid), 64'(dv));
    if (dv) begin
      check({name, "_desc_base"}, 64'(desc_base), 64'(db));
      check({name, "_desc_len"}, 64'(desc_len), 64'(dl));
    end
    check({name, "_drop_cnt"}, 64'(drop_cnt), 64'(drops));
  endtask

  task automatic consume(input string name);
    @(posedge clk); #1;
    desc_ready = 1'b1;
    @(posedge clk); #1;
    desc_ready = 1'b0;
    @(negedge clk); #1;
    check({name, "_desc_cleared"}, 64'(desc_valid), 64'd0);
  endtask

  initial begin
    int nwr;
    int b;
    vec_t v;

    #12;
    check("reset_ram_outputs", 64'({ram_en, ram_we, ram_addr, ram_din}), 64'd0);
    check("reset_desc_outputs", 64'({desc_valid, desc_base, desc_len, drop_cnt}), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // n, err, rd_ptr, consume, base, admit, desc_valid, desc_base, desc_len, drops
    add(64,   0, 0,    1, 0,    1, 1, 0,    64,   0);
    add(65,   0, 0,    1, 32,   1, 1, 32,   65,   0);
    add(100,  1, 0,    0, 65,   1, 0, 0,    0,    1);
    add(20,   0, 0,    1, 65,   1, 1, 65,   20,   1);
    for (int i = 0; i < 10; i++) begin
      b = 75 + 768 * i;
      add(1536, 0, (b + 4000) % 8192, 1, b, 1, 1, b, 1536, 1);
    end
    add(850,  0, 3563, 1, 7755, 1, 1, 7755, 850,  1);
    add(64,   0, 1000, 1, 8180, 1, 1, 8180, 64,   1);
    add(30,   0, 120,  0, 20,   0, 0, 0,    0,    2);
    add(40,   0, 5000, 0, 20,   1, 1, 20,   40,   2);
    add(30,   0, 5000, 1, 40,   0, 1, 20,   40,   3);
    add(1537, 0, 5000, 0, 40,   1, 0, 0,    0,    4);
    add(14,   0, 5000, 1, 40,   1, 1, 40,   14,   4);
    add(13,   0, 5000, 0, 47,   1, 0, 0,    0,    5);
    add(15,   0, 5000, 1, 47,   1, 1, 47,   15,   5);

    foreach (vecs[i]) begin
      v      = vecs[i];
      rd_ptr = AW'(v.rdp);
      nwr    = v.admit ? ((v.n > 1536) ? 1536 : v.n) : 0;
      send_frame(v.n, v.err, AW'(v.base), nwr, (i == 0) ? 8'd0 : 8'($urandom_range(0, 255)), 1'b0);
      check_frame($sformatf("v%0d", i), v.dv, v.db, v.dl, v.drops);
      if (v.consume) consume($sformatf("v%0d", i));
    end

    // Descriptor pending, released by desc_ready in the same cycle the next frame starts.
    rd_ptr = AW'(5000);
    send_frame(20, 0, AW'(55), 20, 8'($urandom_range(0, 255)), 1'b0);
    check_frame("hs_a", 1'b1, 55, 20, 5);
    send_frame(16, 0, AW'(65), 16, 8'($urandom_range(0, 255)), 1'b1);
    check_frame("hs_b", 1'b1, 65, 16, 5);
    consume("hs_b");

    // Asynchronous reset in the middle of a frame.
    for (int k = 0; k < 10; k++) begin
      rx_valid = 1'b1;
      rx_byte  = 8'(k + 100);
      rx_last  = 1'b0;
      rx_err   = 1'b0;
      exp_q.push_back({AW'(73) + AW'(k >> 1), (k % 2 == 1) ? 2'b10 : 2'b01,
                       8'(k + 100), 8'(k + 100)});
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    @(negedge clk); #2;
    rstn = 1'b0;
    #1;
    check("midreset_ram_outputs", 64'({ram_en, ram_we, ram_addr, ram_din}), 64'd0);
    check("midreset_desc_outputs", 64'({desc_valid, desc_base, desc_len, drop_cnt}), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rstn   = 1'b1;
    rd_ptr = '0;
    send_frame(20, 0, AW'(0), 20, 8'($urandom_range(0, 255)), 1'b0);
    check_frame("post_reset", 1'b1, 0, 20, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
